// File: rtl/bot_nav_pkg.sv
// bot_nav_pkg: shared types, field positions and the motor-word packer for the Rojobot navigation controller
package bot_nav_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_TURN_L  = 3'd2,
    S_TURN_R  = 3'd3,
    S_SEARCH  = 3'd4,
    S_REVERSE = 3'd5,
    S_HALT    = 3'd6
  } nav_state_e;
  typedef enum logic [1:0] {L_CENTER, L_LEFT, L_RIGHT, L_LOST} line_e;
  localparam int MC_LDIR = 7;
  localparam int MC_LSPD = 4;
  localparam int MC_RDIR = 3;
  localparam int MC_RSPD = 0;
  localparam int SN_PROXL = 4;
  localparam int SN_PROXR = 3;
  localparam int SN_BLKL = 2;
  localparam int SN_BLKC = 1;
  localparam int SN_BLKR = 0;
  function automatic logic [7:0] pack_mot(logic ldir, logic [2:0] lspd, logic rdir, logic [2:0] rspd);
    logic [7:0] m;
    m = '0;
    m[MC_LDIR] = ldir;
    m[MC_LSPD +: 3] = lspd;
    m[MC_RDIR] = rdir;
    m[MC_RSPD +: 3] = rspd;
    return m;
  endfunction
endpackage

// File: rtl/bot_nav_decode.sv
// bot_nav_decode: classifies the {BlkL,BlkC,BlkR} line sensors as CENTER, LEFT, RIGHT or LOST
import bot_nav_pkg::*;
module bot_nav_decode (
  input  logic [2:0] blk,
  output line_e      line
);
  always_comb
    line = (blk == 3'b000) ? L_LOST :
           (blk == 3'b100 || blk == 3'b110) ? L_LEFT :
           (blk == 3'b001 || blk == 3'b011) ? L_RIGHT : L_CENTER;
endmodule

// File: rtl/bot_nav_ctrl.sv
// bot_nav_ctrl: line-follow / obstacle back-off / bounded search controller driving the Rojobot MotCtl input
// Optional BOT_NAV_STATS_EN adds a saturating lost_cnt of FOLLOW/TURN->SEARCH transitions.
import bot_nav_pkg::*;
module bot_nav_ctrl #(
  parameter logic [2:0] FWD_SPEED    = 3'd6,
  parameter logic [2:0] TURN_SPEED   = 3'd3,
  parameter int         REV_TICKS    = 4,
  parameter int         SEARCH_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        upd_sysregs,
  input  logic [7:0]  Sensors_reg,
  input  logic [7:0]  BotInfo_reg,
  output logic [7:0]  MotCtl_out,
  output logic [2:0]  nav_state,
  output logic        halted,
`ifdef BOT_NAV_STATS_EN
  output logic [15:0] lost_cnt,
`endif
  output logic [7:0]  info_latched
);
  localparam logic [3:0] REV_LOAD = 4'(REV_TICKS - 1);
  localparam logic [7:0] LIMIT = 8'(SEARCH_LIMIT);
  nav_state_e state, state_nx;
  logic [3:0] rev_cnt, rev_nx;
  logic [7:0] srch_cnt, srch_nx, srch_inc;
  logic [7:0] mot_nx;
  logic       obs, eval;
  line_e      line;
  bot_nav_decode u_dec (.blk(Sensors_reg[SN_BLKL:SN_BLKR]), .line(line));
  assign obs = Sensors_reg[SN_PROXL] | Sensors_reg[SN_PROXR];
  assign eval = run & upd_sysregs;
  assign srch_inc = (srch_cnt == 8'hFF) ? srch_cnt : srch_cnt + 8'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rev_cnt <= '0;
      srch_cnt <= '0;
      MotCtl_out <= '0;
      info_latched <= '0;
    end else begin
      state <= state_nx;
      rev_cnt <= rev_nx;
      srch_cnt <= srch_nx;
      MotCtl_out <= mot_nx;
      if (eval) info_latched <= BotInfo_reg;
    end
  end
  always_comb begin
    state_nx = state;
    rev_nx = rev_cnt;
    srch_nx = srch_cnt;
    if (!run) begin
      state_nx = S_IDLE;
      rev_nx = '0;
      srch_nx = '0;
    end else if (upd_sysregs) begin
      if (obs && state != S_REVERSE && state != S_HALT) begin
        state_nx = S_REVERSE;
        rev_nx = REV_LOAD;
      end else begin
        case (state)
          S_IDLE, S_FOLLOW: begin
            state_nx = (line == L_CENTER) ? S_FOLLOW : (line == L_LEFT) ? S_TURN_L :
                       (line == L_RIGHT) ? S_TURN_R : S_SEARCH;
            if (line == L_LOST) srch_nx = '0;
          end
          S_TURN_L, S_TURN_R: begin
            state_nx = Sensors_reg[SN_BLKC] ? S_FOLLOW : (line == L_LOST) ? S_SEARCH : state;
            if (!Sensors_reg[SN_BLKC] && line == L_LOST) srch_nx = '0;
          end
          S_SEARCH: begin
            if (line != L_LOST) state_nx = S_FOLLOW;
            else begin
              srch_nx = srch_inc;
              if (srch_inc == LIMIT) state_nx = S_HALT;
            end
          end
          S_REVERSE: begin
            if (rev_cnt == '0) begin
              state_nx = S_SEARCH;
              srch_nx = '0;
            end else rev_nx = rev_cnt - 4'd1;
          end
          default: state_nx = state;
        endcase
      end
    end
  end
  always_comb begin
    mot_nx = (state_nx == S_FOLLOW) ? pack_mot(1'b1, FWD_SPEED, 1'b1, FWD_SPEED) :
             (state_nx == S_TURN_L) ? pack_mot(1'b0, TURN_SPEED, 1'b1, TURN_SPEED) :
             (state_nx == S_TURN_R || state_nx == S_SEARCH) ? pack_mot(1'b1, TURN_SPEED, 1'b0, TURN_SPEED) :
             (state_nx == S_REVERSE) ? pack_mot(1'b0, TURN_SPEED, 1'b0, TURN_SPEED) : 8'h00;
    nav_state = state;
    halted = (state == S_HALT);
  end
`ifdef BOT_NAV_STATS_EN
  logic lost_ev;
  assign lost_ev = eval && (state == S_FOLLOW || state == S_TURN_L || state == S_TURN_R) && state_nx == S_SEARCH;
  // survives run=0 on purpose: only reset clears the statistic
  always_ff @(posedge clk) begin
    if (reset) lost_cnt <= '0;
    else if (lost_ev && lost_cnt != 16'hFFFF) lost_cnt <= lost_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_bot_nav_ctrl.sv
// tb_bot_nav_ctrl: scoreboard bench for bot_nav_ctrl with directed and random stimulus against a reference model
module tb_bot_nav_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, run = 1'b0, upd_sysregs = 1'b0;
  logic [7:0] Sensors_reg = '0, BotInfo_reg = '0;
  logic [7:0] MotCtl_out, info_latched;
  logic [2:0] nav_state;
  logic halted;
`ifdef BOT_NAV_STATS_EN
  logic [15:0] lost_cnt;
`endif
  bot_nav_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .upd_sysregs(upd_sysregs),
    .Sensors_reg(Sensors_reg), .BotInfo_reg(BotInfo_reg),
    .MotCtl_out(MotCtl_out), .nav_state(nav_state), .halted(halted),
`ifdef BOT_NAV_STATS_EN
    .lost_cnt(lost_cnt),
`endif
    .info_latched(info_latched)
  );
  typedef struct {
    logic [2:0]  st;
    logic [7:0]  mot;
    logic        h;
    logic [7:0]  info;
    logic [15:0] lost;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int m_st = 0, m_rc = 0, m_sc = 0, m_lost = 0;
  logic [7:0] m_info = '0;
  function automatic logic [7:0] mot_of(int st);
    case (st)
      1: return 8'hEE;
      2: return 8'h3B;
      3, 4: return 8'hB3;
      5: return 8'h33;
      default: return 8'h00;
    endcase
  endfunction
  task automatic model(input logic r, input logic u, input logic [7:0] s, input logic [7:0] b, input logic rs);
    int ln, prev;
    ln = int'(s[2:0]);
    prev = m_st;
    if (rs) begin
      m_st = 0; m_rc = 0; m_sc = 0; m_info = '0; m_lost = 0;
      return;
    end
    if (!r) begin
      m_st = 0; m_rc = 0; m_sc = 0;
      return;
    end
    if (!u) return;
    m_info = b;
    if ((s[4] || s[3]) && m_st != 5 && m_st != 6) begin
      m_st = 5; m_rc = 3;
    end else if (m_st <= 1) begin
      if (ln == 0) begin m_st = 4; m_sc = 0; end
      else if (ln == 4 || ln == 6) m_st = 2;
      else if (ln == 1 || ln == 3) m_st = 3;
      else m_st = 1;
    end else if (m_st == 2 || m_st == 3) begin
      if (s[1]) m_st = 1;
      else if (ln == 0) begin m_st = 4; m_sc = 0; end
    end else if (m_st == 4) begin
      if (ln != 0) m_st = 1;
      else begin
        if (m_sc < 255) m_sc++;
        if (m_sc == 16) m_st = 6;
      end
    end else if (m_st == 5) begin
      if (m_rc == 0) begin m_st = 4; m_sc = 0; end
      else m_rc--;
    end
    if (prev >= 1 && prev <= 3 && m_st == 4 && m_lost < 65535) m_lost++;
  endtask
  task automatic cyc(input logic r, input logic u, input logic [7:0] s, input logic rs);
    logic [7:0] b;
    b = 8'($urandom);
    @(negedge clk);
    reset = rs; run = r; upd_sysregs = u; Sensors_reg = s; BotInfo_reg = b;
    model(r, u, s, b, rs);
    q.push_back('{3'(m_st), mot_of(m_st), m_st == 6, m_info, 16'(m_lost)});
  endtask
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("nav_state", 16'(nav_state), 16'(e.st));
      chk("MotCtl_out", 16'(MotCtl_out), 16'(e.mot));
      chk("halted", 16'(halted), 16'(e.h));
      chk("info_latched", 16'(info_latched), 16'(e.info));
`ifdef BOT_NAV_STATS_EN
      chk("lost_cnt", lost_cnt, e.lost);
`endif
    end
  end
  initial begin
    logic [7:0] s;
    logic [2:0] ln;
    cyc(1, 0, 8'h02, 1);
    cyc(1, 0, 8'h02, 0);
    cyc(1, 1, 8'h02, 0);
    cyc(1, 0, 8'h04, 0);
    cyc(1, 0, 8'h04, 0);
    cyc(1, 1, 8'h04, 0);
    cyc(1, 1, 8'h02, 0);
    cyc(1, 1, 8'h12, 0);
    repeat (3) begin cyc(1, 1, 8'h18, 0); cyc(1, 0, 8'h00, 0); end
    cyc(1, 1, 8'h00, 0);
    repeat (16) cyc(1, 1, 8'h00, 0);
    cyc(1, 1, 8'h02, 0);
    cyc(1, 1, 8'h17, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(1, 1, 8'h02, 0);
    cyc(1, 1, 8'h08, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(1, 1, 8'h02, 0);
    cyc(1, 1, 8'h04, 1);
    cyc(1, 1, 8'h02, 0);
    repeat (3) begin cyc(1, 1, 8'h00, 0); cyc(1, 1, 8'h02, 0); end
    cyc(0, 0, 8'h00, 0);
    cyc(1, 1, 8'h02, 0);
    cyc(1, 0, 8'h00, 1);
    repeat (4000) begin
      ln = ($urandom % 5 < 2) ? 3'b000 : 3'($urandom);
      s = {3'($urandom), ($urandom % 8 == 0) ? 2'($urandom) : 2'b00, ln};
      cyc(($urandom % 50) != 0, $urandom % 2 == 0, s, ($urandom % 300) == 0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
